// File: rtl/arb_weight_tracker_if.sv
// Handshake bundle between the arbiter granter side and the weight tracker.
// The tracker takes the slave view; whoever drives requests/grants takes the master view.
interface arb_weight_tracker_if #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 4
) ();
    logic [P_REQUESTER_NUM-1:0]            request;
    logic [P_REQUESTER_NUM-1:0]            grant;
    logic                                  grant_accept;
    logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight;
    logic [P_REQUESTER_NUM-1:0]            request_weight_completed;
    logic                                  round_done;

    modport master (
        output request,
        output grant,
        output grant_accept,
        output weight,
        input  request_weight_completed,
        input  round_done
    );

    modport slave (
        input  request,
        input  grant,
        input  grant_accept,
        input  weight,
        output request_weight_completed,
        output round_done
    );
endinterface

// File: rtl/arb_weight_tracker.sv
// Weighted-round grant bookkeeping: per-requester saturating grant counters, round close/clear.
// Optional macro ARB_WEIGHT_SHADOW_EN freezes weights per round in shadow registers.
module arb_weight_tracker #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 4
) (
    input logic                  clk,
    input logic                  rst,
    arb_weight_tracker_if.slave  bus
);
    localparam logic [P_WEIGHT_W-1:0] CNT_MAX = '1;
    localparam logic [P_WEIGHT_W-1:0] CNT_ONE = P_WEIGHT_W'(1);

    logic [P_WEIGHT_W-1:0]      cnt   [P_REQUESTER_NUM];
    logic [P_WEIGHT_W-1:0]      eff_w [P_REQUESTER_NUM];
    logic [P_REQUESTER_NUM-1:0] completed;
    logic [P_REQUESTER_NUM-1:0] remaining;
    logic                       round_end;
    logic                       round_done;

    function automatic logic [P_WEIGHT_W-1:0] sat_inc(input logic [P_WEIGHT_W-1:0] val);
        return (val == CNT_MAX) ? val : val + CNT_ONE;
    endfunction

`ifdef ARB_WEIGHT_SHADOW_EN
    logic [P_WEIGHT_W-1:0] shadow_w [P_REQUESTER_NUM];
    logic                  load_pending;

    // Shadows reload on the first cycle out of reset and on every round clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_pending <= 1'b1;
            for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                shadow_w[i] <= CNT_ONE;
            end
        end else begin
            load_pending <= 1'b0;
            if (load_pending || round_end) begin
                for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                    shadow_w[i] <= bus.weight[i*P_WEIGHT_W +: P_WEIGHT_W];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            eff_w[i] = shadow_w[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            eff_w[i] = bus.weight[i*P_WEIGHT_W +: P_WEIGHT_W];
        end
    end
`endif

    // A zero weight leaves its requester permanently completed.
    always_comb begin
        completed = '0;
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            completed[i] = (cnt[i] >= eff_w[i]);
        end
    end

    assign remaining = bus.request & ~completed;
    assign round_end = ~|remaining & |bus.request;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_done <= 1'b0;
            for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            round_done <= round_end;
            for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                if (round_end) begin
                    // The grant accepted on the clear edge belongs to the new round.
                    cnt[i] <= (bus.grant_accept && bus.grant[i]) ? CNT_ONE : '0;
                end else if (bus.grant_accept && bus.grant[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    assign bus.request_weight_completed = completed;
    assign bus.round_done               = round_done;
endmodule

// File: tb/tb_arb_weight_tracker.sv
// Directed-vector scoreboard bench for arb_weight_tracker (default build, 3 requesters, 4-bit weights).
module tb_arb_weight_tracker;
    localparam int N = 3;
    localparam int W = 4;

    typedef struct {
        logic [N-1:0] comp;
        logic         done;
        string        name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q [$];

    arb_weight_tracker_if #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W)) bus ();

    arb_weight_tracker #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [N-1:0] ec, input logic ed);
        checks++;
        if (bus.request_weight_completed !== ec || bus.round_done !== ed) begin
            errors++;
            $display("FAIL %s: completed=%b round_done=%b, expected completed=%b round_done=%b",
                     nm, bus.request_weight_completed, bus.round_done, ec, ed);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected just after the next edge.
    task automatic step(input logic [N*W-1:0] wt, input logic [N-1:0] rq, input logic [N-1:0] gt,
                        input logic ac, input logic [N-1:0] ec, input logic ed, input string nm);
        exp_t e;
        @(negedge clk);
        bus.weight       = wt;
        bus.request      = rq;
        bus.grant        = gt;
        bus.grant_accept = ac;
        e.comp = ec;
        e.done = ed;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, e.comp, e.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // Weights packed as {w2, w1, w0}.
    localparam logic [N*W-1:0] W_T1  = {4'd2, 4'd1, 4'd3};
    localparam logic [N*W-1:0] W_T2  = {4'd1, 4'd2, 4'd1};
    localparam logic [N*W-1:0] W_T3  = {4'd0, 4'd2, 4'd1};
    localparam logic [N*W-1:0] W_T4  = {4'd2, 4'd3, 4'd15};
    localparam logic [N*W-1:0] W_T5A = {4'd2, 4'd3, 4'd3};
    localparam logic [N*W-1:0] W_T5B = {4'd2, 4'd3, 4'd1};
    localparam logic [N*W-1:0] W_T6  = {4'd0, 4'd3, 4'd3};
    localparam logic [N*W-1:0] W_T6B = {4'd0, 4'd2, 4'd3};

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.request      = '0;
        bus.grant        = '0;
        bus.grant_accept = 1'b0;
        bus.weight       = W_T1;

        // Reset state: nonzero weights give nothing completed; weight 0 gives completed.
        repeat (2) @(negedge clk);
        #1;
        check("reset_nonzero_w", 3'b000, 1'b0);
        bus.weight = W_T3;
        #1;
        check("reset_zero_w2", 3'b100, 1'b0);
        @(negedge clk);
        bus.weight = W_T1;
        rst = 1'b0;

        // Weights {3,1,2}, grants 0,0,0,1,2,2 then the round closes.
        step(W_T1, 3'b111, 3'b001, 1'b1, 3'b000, 1'b0, "t1_g0a");
        step(W_T1, 3'b111, 3'b001, 1'b1, 3'b000, 1'b0, "t1_g0b");
        step(W_T1, 3'b111, 3'b001, 1'b1, 3'b001, 1'b0, "t1_g0c");
        step(W_T1, 3'b111, 3'b010, 1'b1, 3'b011, 1'b0, "t1_g1");
        step(W_T1, 3'b111, 3'b100, 1'b1, 3'b011, 1'b0, "t1_g2a");
        step(W_T1, 3'b111, 3'b100, 1'b1, 3'b111, 1'b0, "t1_g2b");
        step(W_T1, 3'b111, 3'b000, 1'b0, 3'b000, 1'b1, "t1_clear");
        step(W_T1, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, "t1_idle");

        // Lone requester 1 with weight 2: period-2 rounds, clear edge charges the grant.
        step(W_T2, 3'b010, 3'b010, 1'b1, 3'b000, 1'b0, "t2_a1");
        step(W_T2, 3'b010, 3'b010, 1'b1, 3'b010, 1'b0, "t2_a2");
        step(W_T2, 3'b010, 3'b010, 1'b1, 3'b000, 1'b1, "t2_clr1");
        step(W_T2, 3'b010, 3'b010, 1'b1, 3'b010, 1'b0, "t2_a4");
        step(W_T2, 3'b010, 3'b010, 1'b1, 3'b000, 1'b1, "t2_clr2");
        step(W_T2, 3'b010, 3'b010, 1'b1, 3'b010, 1'b0, "t2_a6");
        step(W_T2, 3'b000, 3'b000, 1'b1, 3'b010, 1'b0, "t2_noreq_hold");

        // Weight 0 on requester 2: exception grant closes the round, then back-to-back clear.
        step(W_T3, 3'b100, 3'b100, 1'b1, 3'b100, 1'b1, "t3_exc_clear");
        step(W_T3, 3'b100, 3'b000, 1'b0, 3'b100, 1'b1, "t3_b2b_clear");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t3_rst_after_done", 3'b100, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation: weight 15, requester 1 keeps budget, 17 grants to requester 0.
        for (int k = 1; k <= 17; k++) begin
            step(W_T4, 3'b011, 3'b001, 1'b1, (k >= 15) ? 3'b001 : 3'b000, 1'b0, "t4_sat");
        end
        step(W_T4, 3'b000, 3'b000, 1'b0, 3'b001, 1'b0, "t4_hold");
        step(W_T4, 3'b011, 3'b010, 1'b1, 3'b001, 1'b0, "t4_g1a");
        step(W_T4, 3'b011, 3'b010, 1'b1, 3'b001, 1'b0, "t4_g1b");
        step(W_T4, 3'b011, 3'b010, 1'b1, 3'b011, 1'b0, "t4_g1c");
        step(W_T4, 3'b011, 3'b000, 1'b0, 3'b000, 1'b1, "t4_clear");

        // Live weight change 3 -> 1 after one accept takes effect at once.
        step(W_T5A, 3'b011, 3'b001, 1'b1, 3'b000, 1'b0, "t5_accept");
        step(W_T5B, 3'b011, 3'b000, 1'b0, 3'b001, 1'b0, "t5_wchange");

        // Build cnt={2,1,0}, then asynchronous reset mid-round.
        step(W_T6, 3'b111, 3'b001, 1'b1, 3'b100, 1'b0, "t6_g0");
        step(W_T6, 3'b111, 3'b010, 1'b1, 3'b100, 1'b0, "t6_g1");
        @(negedge clk);
        bus.grant        = 3'b001;
        bus.grant_accept = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_rst_async", 3'b100, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(W_T6B, 3'b111, 3'b010, 1'b1, 3'b100, 1'b0, "t6_c1_cleared");
        step(W_T6B, 3'b111, 3'b001, 1'b1, 3'b100, 1'b0, "t6_c0_cleared");
        step(W_T6B, 3'b000, 3'b000, 1'b0, 3'b100, 1'b0, "t6_idle");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
